// File: rtl/cmp_initiator.sv
// rtl/cmp_initiator.sv - request/response sequencer that drives the ALU comparator for a settle window
// Optional macro CMP_INIT_CHECK_EN: full consistency decode of cmp_y/flags with rsp_err active.
module cmp_initiator #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_en_n,
  input  logic [WIDTH-1:0] cmp_y,
  input  logic             cmp_carry,
  input  logic             cmp_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_lt,
  output logic             rsp_gt,
  output logic             rsp_eq,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             en_n_q, req_ready_q, rsp_valid_q;
  logic             lt_q, gt_q, eq_q, err_q;
  logic             lt_d, gt_d, eq_d, err_d;

`ifdef CMP_INIT_CHECK_EN
  localparam logic [WIDTH-1:0] YLt = WIDTH'(1);
  localparam logic [WIDTH-1:0] YGt = {1'b1, {(WIDTH-1){1'b0}}};

  // Only the three exact signatures a healthy comparator can produce are trusted.
  always_comb begin
    lt_d  = (cmp_y == YLt) && !cmp_zero && !cmp_carry;
    gt_d  = (cmp_y == YGt) && !cmp_zero && !cmp_carry;
    eq_d  = (cmp_y == '0)  &&  cmp_zero && !cmp_carry;
    err_d = !(lt_d || gt_d || eq_d);
  end
`else
  logic unused_flags;
  assign unused_flags = cmp_carry ^ cmp_zero ^ (^cmp_y);

  always_comb begin
    lt_d  = cmp_y[0];
    gt_d  = cmp_y[WIDTH-1];
    eq_d  = ~cmp_y[0] & ~cmp_y[WIDTH-1];
    err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      en_n_q      <= 1'b1;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q         <= req_a;
            b_q         <= req_b;
            en_n_q      <= 1'b0;
            cnt_q       <= 4'(SETTLE);
            req_ready_q <= 1'b0;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          // Sample on the edge where the counter reaches zero.
          if (cnt_q == 4'd1) begin
            cnt_q       <= '0;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            err_q       <= err_d;
            en_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign cmp_a     = a_q;
  assign cmp_b     = b_q;
  assign cmp_en_n  = en_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_lt    = lt_q;
  assign rsp_gt    = gt_q;
  assign rsp_eq    = eq_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_cmp_initiator.sv
// tb/tb_cmp_initiator.sv - self-checking bench for cmp_initiator (SETTLE=1 and SETTLE=4 instances)
module tb_cmp_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [1:0] req_valid, req_ready, rsp_ready, rsp_valid;
  logic [1:0] cmp_en_n, cmp_carry, cmp_zero, fault;
  logic [1:0] rsp_lt, rsp_gt, rsp_eq, rsp_err;
  logic [7:0] cmp_a [2];
  logic [7:0] cmp_b [2];
  logic [7:0] cmp_y [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_initiator #(.WIDTH(8), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a), .req_b(req_b), .cmp_a(cmp_a[0]), .cmp_b(cmp_b[0]), .cmp_en_n(cmp_en_n[0]),
    .cmp_y(cmp_y[0]), .cmp_carry(cmp_carry[0]), .cmp_zero(cmp_zero[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_lt(rsp_lt[0]), .rsp_gt(rsp_gt[0]),
    .rsp_eq(rsp_eq[0]), .rsp_err(rsp_err[0]));

  cmp_initiator #(.WIDTH(8), .SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a), .req_b(req_b), .cmp_a(cmp_a[1]), .cmp_b(cmp_b[1]), .cmp_en_n(cmp_en_n[1]),
    .cmp_y(cmp_y[1]), .cmp_carry(cmp_carry[1]), .cmp_zero(cmp_zero[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_lt(rsp_lt[1]), .rsp_gt(rsp_gt[1]),
    .rsp_eq(rsp_eq[1]), .rsp_err(rsp_err[1]));

  // Comparator model: result byte 0x01/0x80/0x00 with zero flag on equality; fault forces 0x01 with zero=1.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cmp_y[k]     = 8'hA5;
      cmp_zero[k]  = 1'b0;
      cmp_carry[k] = 1'b0;
      if (!cmp_en_n[k]) begin
        if (fault[k]) begin
          cmp_y[k]    = 8'h01;
          cmp_zero[k] = 1'b1;
        end else if (cmp_a[k] < cmp_b[k]) begin
          cmp_y[k] = 8'h01;
        end else if (cmp_a[k] > cmp_b[k]) begin
          cmp_y[k] = 8'h80;
        end else begin
          cmp_y[k]    = 8'h00;
          cmp_zero[k] = 1'b1;
        end
      end
    end
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Expected {lt,gt,eq,err} straight from the compare rules.
  function automatic logic [3:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input logic flt);
    if (flt) begin
`ifdef CMP_INIT_CHECK_EN
      return 4'b0001;
`else
      return 4'b1000;
`endif
    end
    return {a < b, a > b, a == b, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready[k]), 32'd1);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid[k]), 32'd0);
    chk({nm, "_flags"}, 32'({rsp_lt[k], rsp_gt[k], rsp_eq[k], rsp_err[k]}), 32'd0);
    chk({nm, "_cmp_ab"}, {16'd0, cmp_a[k], cmp_b[k]}, 32'd0);
    chk({nm, "_cmp_en_n"}, 32'(cmp_en_n[k]), 32'd1);
  endtask

  task automatic do_txn(input int k, input logic [7:0] a, input logic [7:0] b, input logic flt,
                        input int hold, input logic [3:0] exp, input string nm);
    int  n;
    int  en_low;
    bit  got;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_req_ready_idle"}, 32'(req_ready[k]), 32'd1);
    fault[k]     = flt;
    req_a        = a;
    req_b        = b;
    req_valid[k] = 1'b1;
    rsp_ready[k] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1; en_low = 0; got = 0;
    while (n < 50) begin
      if (rsp_valid[k]) begin
        got = 1;
        break;
      end
      if (!cmp_en_n[k]) en_low++;
      if (req_ready[k]) chk({nm, "_busy_ready"}, 32'(req_ready[k]), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
    if (!got) return;
    chk({nm, "_latency"}, 32'(n - 1), 32'(settle_of(k)));
    chk({nm, "_en_low_cycles"}, 32'(en_low), 32'(settle_of(k)));
    chk({nm, "_en_released"}, 32'(cmp_en_n[k]), 32'd1);
    chk({nm, "_result"}, 32'({rsp_lt[k], rsp_gt[k], rsp_eq[k], rsp_err[k]}), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_valid"}, 32'(rsp_valid[k]), 32'd1);
      chk({nm, "_hold_result"}, 32'({rsp_lt[k], rsp_gt[k], rsp_eq[k], rsp_err[k]}), 32'(exp));
      chk({nm, "_hold_req_ready"}, 32'(req_ready[k]), 32'd0);
      if (i == 0) begin
        req_a        = ~a;
        req_b        = ~b;
        req_valid[k] = 1'b1;
      end else begin
        req_valid[k] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk({nm, "_done_valid"}, 32'(rsp_valid[k]), 32'd0);
    chk({nm, "_done_req_ready"}, 32'(req_ready[k]), 32'd1);
    chk({nm, "_retain_ab"}, {16'd0, cmp_a[k], cmp_b[k]}, {16'd0, a, b});
    chk({nm, "_idle_en_n"}, 32'(cmp_en_n[k]), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       flt;
    int         k;
    int         hold;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n;
    int pulses;
    logic [7:0] ra, rb;
    logic       rf;
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; fault = '0; req_a = '0; req_b = '0;

    tbl[0] = '{8'h05, 8'h09, 1'b0, 0, 0, 4'b1000};
    tbl[1] = '{8'hC8, 8'h10, 1'b0, 0, 0, 4'b0100};
    tbl[2] = '{8'h3C, 8'h3C, 1'b0, 1, 0, 4'b0010};
    tbl[3] = '{8'h05, 8'h09, 1'b0, 1, 5, 4'b1000};
`ifdef CMP_INIT_CHECK_EN
    tbl[4] = '{8'h05, 8'h09, 1'b1, 0, 1, 4'b0001};
`else
    tbl[4] = '{8'h05, 8'h09, 1'b1, 0, 1, 4'b1000};
`endif
    tbl[5] = '{8'hFF, 8'h00, 1'b0, 1, 2, 4'b0100};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 0, 5, 4'b0010};

    repeat (2) @(negedge clk);
    chk_reset(0, "rst_init1");
    chk_reset(1, "rst_init4");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) do_txn(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].flt, tbl[i].hold, tbl[i].exp,
                            $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      rf = ($urandom_range(0, 7) == 0);
      do_txn(i % 2, ra, rb, rf, int'($urandom_range(0, 3)), ref_cmp(ra, rb, rf),
             $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while a response is being held.
    fault[0] = 1'b0; req_a = 8'h12; req_b = 8'h34; req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_resp_pending", 32'(rsp_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset(0, "rst_resp1");
    chk_reset(1, "rst_resp4");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp_ready_after", 32'(req_ready[0]), 32'd1);

    // Reset while SETTLE=4 instance is still driving: no response may appear.
    fault[1] = 1'b0; req_a = 8'h40; req_b = 8'h20; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("drive_en_low", 32'(cmp_en_n[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("drive_rst_en_n", 32'(cmp_en_n[1]), 32'd1);
    chk("drive_rst_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[1]) pulses++;
    end
    chk("drive_rst_no_rsp", 32'(pulses), 32'd0);
    do_txn(1, 8'h40, 8'h20, 1'b0, 0, 4'b0100, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cmp_initiator.md
# cmp_initiator

Initiator-side sequencer for the ALU comparator. It accepts a compare request over a valid/ready handshake and drives the operands and the active-low comparator enable for a programmable settle window. It then samples and decodes the comparator's result byte and flags, and returns a one-hot less/greater/equal result over a second valid/ready handshake. It sits between the control path and the comparator, so control logic never touches the comparator bus directly.

## Interface
Parameters:
- WIDTH, 8, operand and result-byte width
- SETTLE, 1, cycles operands are held with the enable asserted before sampling; legal 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- cmp_a  out  WIDTH  operand A to comparator
- cmp_b  out  WIDTH  operand B to comparator
- cmp_en_n  out  1  comparator enable, active-low
- cmp_y  in  WIDTH  comparator result byte
- cmp_carry  in  1  comparator carry flag
- cmp_zero  in  1  comparator zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_lt  out  1  A < B (unsigned)
- rsp_gt  out  1  A > B (unsigned)
- rsp_eq  out  1  A == B
- rsp_err  out  1  comparator returned an inconsistent result

## Operation
- FSM states: IDLE, DRIVE, RESP. Reset state is IDLE.
- IDLE: req_ready=1. When req_valid=1 at an edge:
  - register req_a/req_b into cmp_a/cmp_b
  - drive cmp_en_n=0
  - load the settle counter with SETTLE
  - go to DRIVE
- DRIVE: req_ready=0 and cmp_a/cmp_b are stable. The counter decrements each edge. At the edge where it reaches 0:
  - register the decoded result
  - set cmp_en_n=1 and rsp_valid=1
  - go to RESP
- RESP: rsp_* are held stable until the edge with rsp_ready=1. That edge clears rsp_valid and moves to IDLE.
- cmp_a/cmp_b retain the last operands after the compare. Only a new accept changes them.
- Decode with CMP_INIT_CHECK_EN defined:
  - cmp_y==0x01, zero=0, carry=0 → lt
  - cmp_y==0x80, zero=0, carry=0 → gt
  - cmp_y==0x00, zero=1, carry=0 → eq
  - anything else → err=1 and lt/gt/eq=0
- Exactly one of lt/gt/eq/err is 1 in every response.
- req_valid while busy is ignored. The requester must hold the request until req_ready.
- Reset mid-operation: asynchronous return to IDLE.
  - cmp_en_n=1 immediately
  - rsp_valid=0
  - the pending compare is lost; no response is issued

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0
  - rsp_lt/gt/eq/err=0
  - cmp_a=cmp_b=0, cmp_en_n=1
- Accept at edge E0: cmp_en_n goes low after E0. The result is sampled at edge E(SETTLE). rsp_valid goes high after E(SETTLE), and cmp_en_n returns high at the same point.
- Request-to-response latency is SETTLE cycles from accept.
- If rsp_ready is already high, the response completes at E(SETTLE+1). req_ready rises after that edge, so there is no same-cycle bypass.
- Minimum spacing between accepts is SETTLE+2 cycles.
- The comparator must produce valid cmp_y/cmp_carry/cmp_zero within SETTLE cycles of cmp_en_n falling.

## Configuration
- CMP_INIT_CHECK_EN defined: full consistency decode as described in Operation; rsp_err is active.
- CMP_INIT_CHECK_EN undefined:
  - rsp_lt=cmp_y[0], rsp_gt=cmp_y[WIDTH-1], rsp_eq=~cmp_y[0]&~cmp_y[WIDTH-1]
  - cmp_carry and cmp_zero are ignored
  - rsp_err is tied to 0
  - handshakes and timing are unchanged

## Test plan
- Reset: assert rst_n=0 mid-run → all outputs take the listed reset values in the same cycle; req_ready=1 after release.
- Less-than: req_a=0x05, req_b=0x09, bench comparator model, SETTLE=1, rsp_ready=1 → rsp_valid one cycle after accept with rsp_lt=1, others 0; cmp_en_n low exactly 1 cycle.
- Greater/equal: 0xC8 vs 0x10 → rsp_gt=1. 0x3C vs 0x3C → rsp_eq=1. SETTLE=4 → cmp_en_n low exactly 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles and a second req_valid pulsed meanwhile → rsp_* stable, req_ready=0, second request not accepted until the cycle after rsp_ready=1.
- Inconsistent flags (CMP_INIT_CHECK_EN): model returns cmp_y=0x01 with cmp_zero=1 → rsp_err=1, lt/gt/eq=0. Macro undefined → same stimulus gives rsp_lt=1, rsp_err=0.
- Reset in DRIVE: assert rst_n after accept, before sampling → no rsp_valid pulse; the next request completes normally.
